// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Purpose : round-robin arbiter granting one of four requesters access to a
//           shared 2-byte UART transmitter, one frame at a time.
// Latency : req (in IDLE) -> tx_enable = 3 cycles; frame_done -> next tx_enable = 4 cycles.
// Backpr. : requesters hold req until grant_ack; the arbiter holds in WAIT
//           until the transmitter reports frame_done (or the optional watchdog fires).
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to enable the WAIT watchdog
// (limit set by TIMEOUT_CYCLES). Without it WAIT waits forever and
// timeout_err is tied to 0.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   req[3:0]            level requests, bit k = requester k has a frame
//   req_data[63:0]      frame bytes, slice k = {second byte, first byte}
//   frame_done          one-cycle pulse from the transmitter, frame sent
//   tx_enable           one-cycle start pulse to the transmitter
//   tx_byte_one/two     latched bytes of the granted frame
//   grant_ack[3:0]      one-hot pulse, requester k's data has been latched
//   req_done[3:0]       one-hot pulse, requester k's frame completed
//   busy                high whenever the FSM is not in IDLE
//   grant_id[1:0]       current or last granted requester
//   timeout_err         sticky watchdog flag
module uart_tx_arbiter #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] req_data,
  input  logic        frame_done,
  output logic        tx_enable,
  output logic [7:0]  tx_byte_one,
  output logic [7:0]  tx_byte_two,
  output logic [3:0]  grant_ack,
  output logic [3:0]  req_done,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_START = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  gid_q, gid_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  b2_q, b2_d;
  logic        tx_en_q, tx_en_d;
  logic [3:0]  ack_q, ack_d;
  logic [3:0]  done_q, done_d;
  logic        busy_q, busy_d;

  // Round-robin selection
  logic        pick_vld;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        err_q, err_d;
`else
  logic        unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Walk offsets from 3 down to 0 so the smallest offset from ptr_q, i.e.
  // the first set bit at or after the pointer, is the last one to write.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    cand     = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    b1_d    = b1_q;
    b2_d    = b2_q;
    tx_en_d = 1'b0;
    ack_d   = 4'b0000;
    done_d  = 4'b0000;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gid_d   = pick_idx;
          b1_d    = req_data[{pick_idx, 4'b0000} +: 8];
          b2_d    = req_data[{pick_idx, 4'b1000} +: 8];
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Data is already captured, so the requester may now move on.
        ack_d   = 4'b0001 << gid_q;
        state_d = S_START;
      end

      S_START: begin
        tx_en_d = 1'b1;
        state_d = S_WAIT;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d   = 24'd0;
`endif
      end

      S_WAIT: begin
        if (frame_done) begin
          done_d  = 4'b0001 << gid_q;
          // Just-served requester becomes lowest priority next round.
          ptr_d   = gid_q + 2'd1;
          state_d = S_IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
        end else if (cnt_q == TIMEOUT_CYCLES - 24'd1) begin
          // Last allowed WAIT cycle with no frame_done: give up on the frame,
          // still report it done so the requester is not left hanging.
          err_d   = 1'b1;
          done_d  = 4'b0001 << gid_q;
          ptr_d   = gid_q + 2'd1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 24'd1;
`endif
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      gid_q   <= 2'd0;
      b1_q    <= 8'd0;
      b2_q    <= 8'd0;
      tx_en_q <= 1'b0;
      ack_q   <= 4'b0000;
      done_q  <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      b1_q    <= b1_d;
      b2_q    <= b2_d;
      tx_en_q <= tx_en_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 24'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign tx_enable   = tx_en_q;
  assign tx_byte_one = b1_q;
  assign tx_byte_two = b2_q;
  assign grant_ack   = ack_q;
  assign req_done    = done_q;
  assign busy        = busy_q;
  assign grant_id    = gid_q;

endmodule
